// File: rtl/ptme_cadu_monitor.sv
// CADU serial monitor: finds the 32-bit ASM, locks, deserialises each codeblock
// into bytes and verifies the ASM that follows, with a flywheel on isolated misses.
module ptme_cadu_monitor #(
  parameter logic [31:0] Asm            = 32'h1ACFFC1D,
  parameter int          CodeblockBytes = 1275,
  parameter int          MaxMiss        = 3,
  parameter int          CntWidth       = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cadu_bit_i,
  output logic                locked_o,
  output logic [7:0]          byte_o,
  output logic                byte_valid_o,
  output logic                sof_o,
  output logic                eof_o,
  output logic [CntWidth-1:0] frame_cnt_o,
  output logic [CntWidth-1:0] asm_miss_cnt_o,
  output logic                sync_loss_o
);

  localparam int FrameBits = CodeblockBytes * 8;
  // One counter serves both the codeblock and the 32-bit marker check.
  localparam int BitW  = $clog2((FrameBits > 32) ? FrameBits : 32);
  localparam int MissW = $clog2(MaxMiss + 1);

  localparam logic [BitW-1:0]  LastDataBit = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0]  LastAsmBit  = BitW'(31);
  localparam logic [MissW-1:0] MissLimit   = MissW'(MaxMiss);

  typedef enum logic [1:0] {SEARCH, DATA, CHECK} state_t;

  state_t                state_reg;
  logic [30:0]           sr_reg;
  logic [7:0]            byte_sr_reg;
  logic [BitW-1:0]       bit_cnt_reg;
  logic [MissW-1:0]      miss_cnt_reg;
  logic                  locked_reg;
  logic [7:0]            byte_reg;
  logic                  byte_valid_reg;
  logic                  sof_reg;
  logic                  eof_reg;
  logic [CntWidth-1:0]   frame_cnt_reg;
  logic [CntWidth-1:0]   asm_miss_cnt_reg;
  logic                  sync_loss_reg;

  logic [31:0]           window;
  logic [7:0]            byte_next;
  logic [MissW-1:0]      miss_cnt_next;

  assign window        = {sr_reg, cadu_bit_i};
  assign byte_next     = {byte_sr_reg[6:0], cadu_bit_i};
  assign miss_cnt_next = miss_cnt_reg + MissW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg        <= SEARCH;
      sr_reg           <= '0;
      byte_sr_reg      <= '0;
      bit_cnt_reg      <= '0;
      miss_cnt_reg     <= '0;
      locked_reg       <= 1'b0;
      byte_reg         <= '0;
      byte_valid_reg   <= 1'b0;
      sof_reg          <= 1'b0;
      eof_reg          <= 1'b0;
      frame_cnt_reg    <= '0;
      asm_miss_cnt_reg <= '0;
      sync_loss_reg    <= 1'b0;
    end else begin
      sr_reg         <= window[30:0];
      byte_valid_reg <= 1'b0;
      sof_reg        <= 1'b0;
      eof_reg        <= 1'b0;
      sync_loss_reg  <= 1'b0;

      case (state_reg)
        SEARCH: begin
          if (window == Asm) begin
            state_reg    <= DATA;
            bit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            locked_reg   <= 1'b1;
          end
        end

        DATA: begin
          byte_sr_reg <= byte_next;
          if (bit_cnt_reg[2:0] == 3'd7) begin
            byte_reg       <= byte_next;
            byte_valid_reg <= 1'b1;
            sof_reg        <= (bit_cnt_reg[BitW-1:3] == '0);
            eof_reg        <= (bit_cnt_reg == LastDataBit);
          end
          if (bit_cnt_reg == LastDataBit) begin
            frame_cnt_reg <= frame_cnt_reg + CntWidth'(1);
            bit_cnt_reg   <= '0;
            state_reg     <= CHECK;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BitW'(1);
          end
        end

        CHECK: begin
          if (bit_cnt_reg == LastAsmBit) begin
            bit_cnt_reg <= '0;
            if (window == Asm) begin
              miss_cnt_reg <= '0;
              state_reg    <= DATA;
            end else begin
              asm_miss_cnt_reg <= asm_miss_cnt_reg + CntWidth'(1);
              miss_cnt_reg     <= miss_cnt_next;
              if (miss_cnt_next == MissLimit) begin
                state_reg     <= SEARCH;
                locked_reg    <= 1'b0;
                sync_loss_reg <= 1'b1;
              end else begin
                // Flywheel: assume the next codeblock starts at its nominal position.
                state_reg <= DATA;
              end
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BitW'(1);
          end
        end

        default: state_reg <= SEARCH;
      endcase
    end
  end

  assign locked_o       = locked_reg;
  assign byte_o         = byte_reg;
  assign byte_valid_o   = byte_valid_reg;
  assign sof_o          = sof_reg;
  assign eof_o          = eof_reg;
  assign frame_cnt_o    = frame_cnt_reg;
  assign asm_miss_cnt_o = asm_miss_cnt_reg;
  assign sync_loss_o    = sync_loss_reg;

endmodule

// File: tb/tb_ptme_cadu_monitor.sv
// Bench for ptme_cadu_monitor: random and directed CADU streams checked every
// cycle against a frame-position model, plus literal expectations per scenario.
module tb_ptme_cadu_monitor;

  localparam int          CB  = 4;
  localparam int          MM  = 2;
  localparam int          CW  = 32;
  localparam logic [31:0] ASM = 32'h1ACFFC1D;
  localparam logic [31:0] BAD = 32'h1ACFFC1C;
  localparam int          PERIOD_BITS = CB * 8 + 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cadu_bit_i = 1'b0;
  logic          locked_o;
  logic [7:0]    byte_o;
  logic          byte_valid_o;
  logic          sof_o;
  logic          eof_o;
  logic [CW-1:0] frame_cnt_o;
  logic [CW-1:0] asm_miss_cnt_o;
  logic          sync_loss_o;

  ptme_cadu_monitor #(
    .Asm(ASM), .CodeblockBytes(CB), .MaxMiss(MM), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .cadu_bit_i(cadu_bit_i),
    .locked_o(locked_o), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .sof_o(sof_o), .eof_o(eof_o), .frame_cnt_o(frame_cnt_o),
    .asm_miss_cnt_o(asm_miss_cnt_o), .sync_loss_o(sync_loss_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: lock flag, bit position inside the ASM+codeblock period, line history.
  bit          m_locked = 0;
  int          m_pos = 0;
  int          m_miss = 0;
  logic [31:0] m_hist = '0;
  logic [31:0] e_frames = '0;
  logic [31:0] e_misses = '0;
  logic [7:0]  e_byte = '0;
  bit          e_valid = 0, e_sof = 0, e_eof = 0, e_loss = 0;

  logic [7:0] cap[$];
  int sof_n = 0, eof_n = 0, loss_n = 0;

  always @(posedge clk) begin
    #2;
    if (byte_valid_o === 1'b1) begin
      cap.push_back(byte_o);
      if (sof_o === 1'b1) sof_n++;
      if (eof_o === 1'b1) eof_n++;
    end
    if (sync_loss_o === 1'b1) loss_n++;
  end

  task automatic model_step(input logic b, input logic r);
    e_valid = 0; e_sof = 0; e_eof = 0; e_loss = 0;
    if (r) begin
      m_locked = 0; m_pos = 0; m_miss = 0; m_hist = '0;
      e_frames = '0; e_misses = '0; e_byte = '0;
      return;
    end
    m_hist = {m_hist[30:0], b};
    if (!m_locked) begin
      if (m_hist == ASM) begin
        m_locked = 1; m_pos = 0; m_miss = 0;
      end
    end else begin
      if (m_pos < CB * 8) begin
        if (m_pos % 8 == 7) begin
          e_byte  = m_hist[7:0];
          e_valid = 1;
          e_sof   = (m_pos / 8 == 0);
          e_eof   = (m_pos == CB * 8 - 1);
          if (e_eof) e_frames++;
        end
      end else if (m_pos == PERIOD_BITS - 1) begin
        if (m_hist == ASM) m_miss = 0;
        else begin
          e_misses++;
          m_miss++;
          if (m_miss == MM) begin
            m_locked = 0;
            e_loss = 1;
          end
        end
      end
      m_pos = (m_pos + 1) % PERIOD_BITS;
    end
  endtask

  // Compare outputs of the previous edge, then drive the next bit.
  task automatic step(input logic b, input logic r);
    @(negedge clk);
    checks++;
    if (locked_o !== m_locked || byte_o !== e_byte || byte_valid_o !== e_valid ||
        sof_o !== e_sof || eof_o !== e_eof || sync_loss_o !== e_loss ||
        frame_cnt_o !== e_frames || asm_miss_cnt_o !== e_misses) begin
      errors++;
      $display("FAIL cycle %0d: got lock=%b byte=%h v=%b sof=%b eof=%b loss=%b fr=%0d miss=%0d, want lock=%b byte=%h v=%b sof=%b eof=%b loss=%b fr=%0d miss=%0d",
               cyc, locked_o, byte_o, byte_valid_o, sof_o, eof_o, sync_loss_o, frame_cnt_o, asm_miss_cnt_o,
               m_locked, e_byte, e_valid, e_sof, e_eof, e_loss, e_frames, e_misses);
    end
    rst_i = r;
    cadu_bit_i = b;
    model_step(b, r);
    cyc++;
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end else
      $display("check %s = %0h", name, act);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
  endtask

  task automatic send32(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) step(v[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic rand_bytes(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
  endtask

  // Send an ASM and pin that lock appears exactly after its 32th bit.
  task automatic send_asm_checked(input string name);
    for (int i = 31; i >= 1; i--) step(ASM[i], 1'b0);
    settle();
    lit({name, "_unlocked_before_last_bit"}, {31'd0, locked_o}, 32'd0);
    step(ASM[0], 1'b0);
    settle();
    lit({name, "_locked_after_32nd_bit"}, {31'd0, locked_o}, 32'd1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    cap.delete();
    sof_n = 0; eof_n = 0; loss_n = 0;
  endtask

  initial begin
    logic [31:0] packed_bytes;
    int eof_snap;

    do_reset();
    settle();
    lit("reset_locked", {31'd0, locked_o}, 32'd0);
    lit("reset_frames", frame_cnt_o, 32'd0);
    lit("reset_misses", asm_miss_cnt_o, 32'd0);
    lit("reset_valid", {31'd0, byte_valid_o}, 32'd0);

    // 1: single CADU
    idle(20);
    send_asm_checked("t1");
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h00); send_byte(8'hFF);
    settle();
    lit("t1_frames", frame_cnt_o, 32'd1);
    lit("t1_nbytes", cap.size(), 32'd4);
    if (cap.size() == 4) begin
      packed_bytes = {cap[0], cap[1], cap[2], cap[3]};
      lit("t1_bytes", packed_bytes, 32'hA53C00FF);
    end
    lit("t1_sof_count", sof_n, 32'd1);
    lit("t1_eof_count", eof_n, 32'd1);

    // 2: ten back-to-back CADUs
    do_reset();
    idle(7);
    for (int f = 0; f < 10; f++) begin
      send32(ASM);
      rand_bytes(CB);
    end
    settle();
    lit("t2_frames", frame_cnt_o, 32'd10);
    lit("t2_nbytes", cap.size(), 32'd40);
    lit("t2_misses", asm_miss_cnt_o, 32'd0);
    lit("t2_sync_loss", loss_n, 32'd0);

    // 3: single corrupted ASM, flywheel, then recovery clears the run
    send32(BAD);
    settle();
    lit("t3_misses", asm_miss_cnt_o, 32'd1);
    lit("t3_locked", {31'd0, locked_o}, 32'd1);
    rand_bytes(CB);
    settle();
    lit("t3_flywheel_frames", frame_cnt_o, 32'd11);
    send32(ASM); rand_bytes(CB);
    send32(BAD);
    settle();
    lit("t3_miss_run_cleared", {31'd0, locked_o}, 32'd1);
    lit("t3_misses2", asm_miss_cnt_o, 32'd2);
    rand_bytes(CB);
    send32(ASM); rand_bytes(CB);

    // 4: two consecutive bad ASMs lose lock
    send32(BAD); rand_bytes(CB);
    loss_n = 0;
    send32(BAD);
    settle();
    lit("t4_locked", {31'd0, locked_o}, 32'd0);
    lit("t4_misses", asm_miss_cnt_o, 32'd4);
    lit("t4_frames", frame_cnt_o, 32'd15);
    idle(40);
    lit("t4_loss_once", loss_n, 32'd1);
    send_asm_checked("t4_relock");
    send_byte(8'h5A); send_byte(8'hC3); rand_bytes(CB - 2);
    settle();
    lit("t4_relock_frames", frame_cnt_o, 32'd16);

    // 5: random noise, then a marker preceded by 0x1A
    do_reset();
    for (int i = 0; i < 1000; i++) step(1'($urandom_range(0, 1)), 1'b0);
    settle();
    lit("t5_locked", {31'd0, locked_o}, 32'd0);
    lit("t5_frames", frame_cnt_o, 32'd0);
    lit("t5_misses", asm_miss_cnt_o, 32'd0);
    lit("t5_nbytes", cap.size(), 32'd0);
    send_byte(8'h1A);
    send_asm_checked("t5");
    rand_bytes(CB);

    // 6: reset mid-frame discards the partial codeblock
    send32(ASM);
    rand_bytes(2);
    eof_snap = eof_n;
    step(1'b0, 1'b1);
    settle();
    lit("t6_locked", {31'd0, locked_o}, 32'd0);
    lit("t6_byte", {24'd0, byte_o}, 32'd0);
    lit("t6_valid", {31'd0, byte_valid_o}, 32'd0);
    lit("t6_frames", frame_cnt_o, 32'd0);
    step(1'b0, 1'b0);
    idle(16);
    lit("t6_no_eof", eof_n, eof_snap);
    send32(ASM);
    rand_bytes(CB);
    step(1'b0, 1'b0);
    settle();
    lit("t6_fresh_frames", frame_cnt_o, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
